// File: rtl/carry_select_adder_pkg.sv
// Shared helpers for the carry-select adder: block count and block bit ranges.
package carry_select_adder_pkg;

  function automatic int csa_num_blocks(input int width, input int block);
    return (width + block - 1) / block;
  endfunction

  // The last block is truncated when WIDTH is not a multiple of BLOCK.
  function automatic int csa_block_hi(input int k, input int width, input int block);
    return ((k + 1) * block < width) ? (k + 1) * block - 1 : width - 1;
  endfunction

endpackage

// File: rtl/rca_block.sv
// N-bit combinational ripple-carry adder, the building block of each select block.
module rca_block #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic [N:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder with a single output register: {cout,sum} = a + b + cin, 1-cycle latency.
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = csa_num_blocks(WIDTH, BLOCK);

  if (WIDTH < 1 || BLOCK < 1 || BLOCK > WIDTH) begin : g_param_check
    $error("carry_select_adder: illegal WIDTH=%0d BLOCK=%0d", WIDTH, BLOCK);
  end

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    localparam int HI = csa_block_hi(k, WIDTH, BLOCK);
    localparam int N  = HI - LO + 1;

    logic blk_cout;

    if (k == 0) begin : g_first
      rca_block #(.N(N)) u_rca (
        .a    (a[HI:LO]),
        .b    (b[HI:LO]),
        .cin  (cin),
        .sum  (sum_c[HI:LO]),
        .cout (blk_cout)
      );
    end else begin : g_select
      logic [N-1:0] sum0, sum1;
      logic         cout0, cout1;

      rca_block #(.N(N)) u_rca0 (
        .a    (a[HI:LO]),
        .b    (b[HI:LO]),
        .cin  (1'b0),
        .sum  (sum0),
        .cout (cout0)
      );
      rca_block #(.N(N)) u_rca1 (
        .a    (a[HI:LO]),
        .b    (b[HI:LO]),
        .cin  (1'b1),
        .sum  (sum1),
        .cout (cout1)
      );

      // Real carry from the previous block picks the speculative result.
      assign sum_c[HI:LO] = g_blk[k-1].blk_cout ? sum1  : sum0;
      assign blk_cout     = g_blk[k-1].blk_cout ? cout1 : cout0;
    end
  end

  assign cout_c = g_blk[NB-1].blk_cout;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  always_comb begin
    valid_d = in_valid;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (in_valid) begin
      sum_d  = sum_c;
      cout_d = cout_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench: four WIDTH=4 variants (BLOCK 1..4) plus one WIDTH=16/BLOCK=4 instance.
module tb_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [15:0] a16, b16;
  logic        cin16;

  logic        ov4 [4];
  logic [3:0]  s4  [4];
  logic        c4  [4];
  logic        ov16;
  logic [15:0] s16;
  logic        c16;

  int tests = 0;
  int fails = 0;

  logic [4:0]  q4  [$];
  logic [16:0] q16 [$];
  logic        exp_v;
  logic [4:0]  held4;
  logic [16:0] held16;

  always #5 clk = ~clk;

  carry_select_adder #(.WIDTH(4), .BLOCK(1)) u_w4b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4[0]), .sum(s4[0]), .cout(c4[0]));
  carry_select_adder #(.WIDTH(4), .BLOCK(2)) u_w4b2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4[1]), .sum(s4[1]), .cout(c4[1]));
  carry_select_adder #(.WIDTH(4), .BLOCK(3)) u_w4b3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4[2]), .sum(s4[2]), .cout(c4[2]));
  carry_select_adder #(.WIDTH(4), .BLOCK(4)) u_w4b4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4[3]), .sum(s4[3]), .cout(c4[3]));
  carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_w16b4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .sum(s16), .cout(c16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    if (exp_v) begin
      chk("sb_depth_w4", q4.size(), 1);
      chk("sb_depth_w16", q16.size(), 1);
      if (q4.size() > 0)  held4  = q4.pop_front();
      if (q16.size() > 0) held16 = q16.pop_front();
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("valid_w4_b%0d", j + 1), 32'(ov4[j]), 32'(exp_v));
      chk($sformatf("result_w4_b%0d", j + 1), 32'({c4[j], s4[j]}), 32'(held4));
    end
    chk("valid_w16_b4", 32'(ov16), 32'(exp_v));
    chk("result_w16_b4", 32'({c16, s16}), 32'(held16));
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input logic v, input logic r, input logic [3:0] xa, input logic [3:0] xb,
                      input logic xc);
    logic [15:0] ya, yb;
    logic        yc;
    ya = 16'($urandom);
    yb = 16'($urandom);
    yc = 1'($urandom);
    @(negedge clk);
    rst = r; in_valid = v;
    a4 = xa; b4 = xb; cin4 = xc;
    a16 = ya; b16 = yb; cin16 = yc;
    if (r) begin
      q4.delete(); q16.delete();
      exp_v = 1'b0; held4 = '0; held16 = '0;
    end else begin
      exp_v = v;
      if (v) begin
        q4.push_back(5'(xa) + 5'(xb) + 5'(xc));
        q16.push_back(17'(ya) + 17'(yb) + 17'(yc));
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [3:0] ra, rb;
    rst = 1'b1; in_valid = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    exp_v = 1'b0; held4 = '0; held16 = '0;

    // Reset held for two cycles with valid random operands.
    for (int i = 0; i < 2; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      step(1'b1, 1'b1, ra, rb, 1'($urandom));
    end

    // Directed back-to-back vectors.
    step(1'b1, 1'b0, 4'b1010, 4'b0101, 1'b0);
    chk("dir0_const", 32'({c4[1], s4[1]}), 32'h0f);
    step(1'b1, 1'b0, 4'b0110, 4'b1100, 1'b1);
    chk("dir1_const", 32'({c4[1], s4[1]}), 32'h13);
    step(1'b1, 1'b0, 4'b1011, 4'b0010, 1'b1);
    chk("dir2_const", 32'({c4[1], s4[1]}), 32'h0e);
    step(1'b1, 1'b0, 4'b0100, 4'b0110, 1'b0);
    chk("dir3_const", 32'({c4[1], s4[1]}), 32'h0a);

    // Block-boundary carry, then full propagation.
    step(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b0);
    chk("boundary_const", 32'({c4[1], s4[1]}), 32'h04);
    step(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
    chk("full_prop_const", 32'({c4[1], s4[1]}), 32'h10);

    // Hold: outputs frozen while in_valid is low, even with changing operands.
    step(1'b1, 1'b0, 4'b0111, 4'b0110, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      step(1'b0, 1'b0, ra, rb, 1'b1);
    end
    step(1'b1, 1'b0, 4'b1001, 4'b1001, 1'b0);

    // Exhaustive sweep across all four BLOCK variants, random 16-bit alongside.
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b0, i[3:0], i[7:4], i[8]);
    end

    // Reset sampled with a valid input: that result is dropped.
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    // Reset on the cycle after a valid input clears the registered result.
    step(1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    step(1'b1, 1'b0, 4'b0010, 4'b0011, 1'b1);

    // A few more random cycles, mixing idle cycles in.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      step(1'($urandom), 1'b0, ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
